// File: rtl/mult_table_pkg.sv
// Shared widths and types for the times-table arbiter slice.
// Used by the arbiter top, its round-robin picker and the bus interface.
package mult_table_pkg;
  localparam int OP_W     = 3;
  localparam int RES_W    = 6;
  localparam int ADDR_W   = 6;
  localparam int MAX_NREQ = 8;

  typedef logic [OP_W-1:0]   operand_t;
  typedef logic [RES_W-1:0]  result_t;
  typedef logic [ADDR_W-1:0] mem_addr_t;

  function automatic result_t mult_op(input operand_t a, input operand_t b);
    return result_t'(a) * result_t'(b);
  endfunction
endpackage

// File: rtl/mult_table_arbiter_if.sv
// Request/response and memory-port bundle for mult_table_arbiter.
// rsp_err exists only when MULT_TABLE_ARB_SELFCHECK_EN is defined.
interface mult_table_arbiter_if
  import mult_table_pkg::*;
#(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]      req_valid;
  logic [OP_W*NREQ-1:0] req_a;
  logic [OP_W*NREQ-1:0] req_b;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      rsp_valid;
  result_t              rsp_result;
  logic                 mem_en;
  mem_addr_t            mem_addr;
  result_t              mem_data;
`ifdef MULT_TABLE_ARB_SELFCHECK_EN
  logic                 rsp_err;

  modport slave (
    input  req_valid, req_a, req_b, mem_data,
    output req_ready, rsp_valid, rsp_result, mem_en, mem_addr, rsp_err
  );
  modport master (
    output req_valid, req_a, req_b, mem_data,
    input  req_ready, rsp_valid, rsp_result, mem_en, mem_addr, rsp_err
  );
`else
  modport slave (
    input  req_valid, req_a, req_b, mem_data,
    output req_ready, rsp_valid, rsp_result, mem_en, mem_addr
  );
  modport master (
    output req_valid, req_a, req_b, mem_data,
    input  req_ready, rsp_valid, rsp_result, mem_en, mem_addr
  );
`endif
endinterface

// File: rtl/mult_table_arbiter_rr_grant.sv
// Combinational round-robin picker: searches from last_grant+1 upward,
// wrapping, and returns the first requesting index one-hot and encoded.
module rr_grant #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);
  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    gnt_vld  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = int'(last_grant) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = IDX_W'(cand);
      if (!gnt_vld && req[cand_idx]) begin
        gnt[cand_idx] = 1'b1;
        gnt_idx       = cand_idx;
        gnt_vld       = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mult_table_arbiter.sv
// Shares the single-port 64x6 times-table memory among NREQ requesters.
// Optional MULT_TABLE_ARB_SELFCHECK_EN adds an a*b cross-check and rsp_err.
module mult_table_arbiter
  import mult_table_pkg::*;
#(
  parameter int NREQ = 4
) (
  input logic                clk,
  input logic                rst_n,
  mult_table_arbiter_if.slave bus
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef logic [IDX_W-1:0] idx_t;

  logic [NREQ-1:0] gnt;
  idx_t            gnt_idx;
  logic            gnt_vld;
  logic            hs;
  operand_t        gnt_a, gnt_b;

  idx_t      last_grant_q, last_grant_d;
  mem_addr_t mem_addr_q, mem_addr_d;
  logic      s1_vld_q, s1_vld_d;
  idx_t      s1_own_q, s1_own_d;
  logic      s2_vld_q, s2_vld_d;
  idx_t      s2_own_q, s2_own_d;
  result_t   s2_data_q, s2_data_d;
`ifdef MULT_TABLE_ARB_SELFCHECK_EN
  operand_t  s1_a_q, s1_a_d;
  operand_t  s1_b_q, s1_b_d;
  logic      s2_err_q, s2_err_d;
`endif

  rr_grant #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr_grant (
    .req       (bus.req_valid),
    .last_grant(last_grant_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_vld   (gnt_vld)
  );

  always_comb begin
    gnt_a = '0;
    gnt_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gnt_a = gnt_a | bus.req_a[i*OP_W +: OP_W];
        gnt_b = gnt_b | bus.req_b[i*OP_W +: OP_W];
      end
    end
  end

  // Ready is masked in reset so no handshake can complete while rst_n is low.
  always_comb begin
    hs            = rst_n & gnt_vld;
    bus.req_ready = rst_n ? gnt : '0;
    bus.mem_en    = hs;
    mem_addr_d    = hs ? {gnt_a, gnt_b} : mem_addr_q;
    bus.mem_addr  = mem_addr_d;
    last_grant_d  = hs ? gnt_idx : last_grant_q;
    s1_vld_d      = hs;
    s1_own_d      = hs ? gnt_idx : s1_own_q;
    s2_vld_d      = s1_vld_q;
    s2_own_d      = s1_own_q;
    s2_data_d     = s1_vld_q ? bus.mem_data : s2_data_q;
`ifdef MULT_TABLE_ARB_SELFCHECK_EN
    s1_a_d        = hs ? gnt_a : s1_a_q;
    s1_b_d        = hs ? gnt_b : s1_b_q;
    s2_err_d      = s1_vld_q && (bus.mem_data != mult_op(s1_a_q, s1_b_q));
`endif
  end

  always_comb begin
    bus.rsp_valid  = s2_vld_q ? (NREQ'(1) << s2_own_q) : '0;
    bus.rsp_result = s2_data_q;
`ifdef MULT_TABLE_ARB_SELFCHECK_EN
    bus.rsp_err    = s2_err_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= idx_t'(NREQ - 1);
      mem_addr_q   <= '0;
      s1_vld_q     <= 1'b0;
      s1_own_q     <= '0;
      s2_vld_q     <= 1'b0;
      s2_own_q     <= '0;
      s2_data_q    <= '0;
`ifdef MULT_TABLE_ARB_SELFCHECK_EN
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s2_err_q     <= 1'b0;
`endif
    end else begin
      last_grant_q <= last_grant_d;
      mem_addr_q   <= mem_addr_d;
      s1_vld_q     <= s1_vld_d;
      s1_own_q     <= s1_own_d;
      s2_vld_q     <= s2_vld_d;
      s2_own_q     <= s2_own_d;
      s2_data_q    <= s2_data_d;
`ifdef MULT_TABLE_ARB_SELFCHECK_EN
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s2_err_q     <= s2_err_d;
`endif
    end
  end
endmodule

// File: tb/tb_mult_table_arbiter.sv
// Bench for mult_table_arbiter: cycle-level response model plus directed
// literal checks. Honours MULT_TABLE_ARB_SELFCHECK_EN for the rsp_err path.
module tb_mult_table_arbiter;
  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mult_table_arbiter_if #(.NREQ(NREQ)) bus ();

  mult_table_arbiter #(.NREQ(NREQ)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Synchronous-read times table; the 6x6 entry is corrupted when self-check is built.
  always @(posedge clk) begin
    if (bus.mem_en) begin
`ifdef MULT_TABLE_ARB_SELFCHECK_EN
      if (bus.mem_addr == 6'o66) bus.mem_data <= 6'd35;
      else
`endif
      bus.mem_data <= 6'(bus.mem_addr[5:3] * bus.mem_addr[2:0]);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each accepted request schedules its response two cycles ahead.
  int cyc = 0;
  int lg = NREQ - 1;
  int addr_last = 0;
  int res_last = 0;
  bit pv[4];
  int po[4];
  int pr[4];
  bit pe[4];
  bit exp_hs;
  int g, c, s, ea, eb;

  initial for (int i = 0; i < 4; i++) pv[i] = 1'b0;

  always @(negedge clk) begin
    exp_hs = 1'b0;
    g = 0;
    if (rst_n) begin
      for (int i = 1; i <= NREQ; i++) begin
        c = (lg + i) % NREQ;
        if (!exp_hs && bus.req_valid[c]) begin
          exp_hs = 1'b1;
          g = c;
        end
      end
    end
    ea = int'(bus.req_a[3*g +: 3]);
    eb = int'(bus.req_b[3*g +: 3]);
    chk("req_ready", int'(bus.req_ready), exp_hs ? (1 << g) : 0);
    chk("mem_en", int'(bus.mem_en), int'(exp_hs));
    chk("mem_addr", int'(bus.mem_addr), exp_hs ? ea * 8 + eb : addr_last);
    s = cyc % 4;
    chk("rsp_valid", int'(bus.rsp_valid), pv[s] ? (1 << po[s]) : 0);
    if (pv[s]) res_last = pr[s];
    chk("rsp_result", int'(bus.rsp_result), res_last);
`ifdef MULT_TABLE_ARB_SELFCHECK_EN
    chk("rsp_err", int'(bus.rsp_err), pv[s] ? int'(pe[s]) : 0);
`endif
    pv[s] = 1'b0;
    if (!rst_n) begin
      lg = NREQ - 1;
      addr_last = 0;
      res_last = 0;
      for (int i = 0; i < 4; i++) pv[i] = 1'b0;
    end else if (exp_hs) begin
      lg = g;
      addr_last = ea * 8 + eb;
      pv[(cyc + 2) % 4] = 1'b1;
      po[(cyc + 2) % 4] = g;
      pr[(cyc + 2) % 4] = ea * eb;
      pe[(cyc + 2) % 4] = 1'b0;
`ifdef MULT_TABLE_ARB_SELFCHECK_EN
      if (ea == 6 && eb == 6) begin
        pr[(cyc + 2) % 4] = 35;
        pe[(cyc + 2) % 4] = 1'b1;
      end
`endif
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [11:0] a, input logic [11:0] b);
    bus.req_valid = v;
    bus.req_a = a;
    bus.req_b = b;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(4'b0000, 12'o0, 12'o0);
    repeat (3) tick();
    rst_n = 1'b1;

    // single request 3x5
    drive(4'b0001, 12'o0003, 12'o0005);
    @(negedge clk);
    chk("single_mem_en", int'(bus.mem_en), 1);
    chk("single_mem_addr", int'(bus.mem_addr), 8'o35);
    chk("single_ready", int'(bus.req_ready), 1);
    tick();
    drive(4'b0000, 12'o0, 12'o0);
    tick();
    @(negedge clk);
    chk("single_rsp_valid", int'(bus.rsp_valid), 1);
    chk("single_rsp_result", int'(bus.rsp_result), 15);
    tick();
    tick();

    // reset one cycle after a grant to requester 2
    drive(4'b0100, 12'o0200, 12'o0300);
    tick();
    drive(4'b0000, 12'o0, 12'o0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
      chk("rst_rsp_result", int'(bus.rsp_result), 0);
      chk("rst_mem_addr", int'(bus.mem_addr), 0);
      tick();
    end

    // contention: all valid, a_i=i, b=7
    drive(4'b1111, 12'o3210, 12'o7777);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k < 8) chk("cont_grant", int'(bus.req_ready), 1 << (k % 4));
      if (k >= 2) begin
        chk("cont_rsp_owner", int'(bus.rsp_valid), 1 << ((k - 2) % 4));
        chk("cont_rsp_result", int'(bus.rsp_result), ((k - 2) % 4) * 7);
      end
      tick();
      if (k == 7) drive(4'b0000, 12'o0, 12'o0);
    end

    // maximum product streamed by requester 2
    drive(4'b0100, 12'o0700, 12'o0700);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk("max_mem_en", int'(bus.mem_en), (k < 5) ? 1 : 0);
      if (k >= 2) begin
        chk("max_rsp_valid", int'(bus.rsp_valid), 4'b0100);
        chk("max_rsp_result", int'(bus.rsp_result), 49);
      end
      tick();
      if (k == 4) drive(4'b0000, 12'o0, 12'o0);
    end

    // fairness after idle
    drive(4'b0010, 12'o0010, 12'o0040);
    @(negedge clk);
    chk("fair_first", int'(bus.req_ready), 4'b0010);
    tick();
    drive(4'b0000, 12'o0, 12'o0);
    repeat (3) tick();
    drive(4'b1001, 12'o5002, 12'o3002);
    @(negedge clk);
    chk("fair_r3", int'(bus.req_ready), 4'b1000);
    tick();
    drive(4'b0001, 12'o5002, 12'o3002);
    @(negedge clk);
    chk("fair_r0", int'(bus.req_ready), 4'b0001);
    tick();
    drive(4'b0000, 12'o0, 12'o0);
    repeat (3) tick();

    // mixed patterns, checked by the model
    drive(4'b0101, 12'o1234, 12'o7654);
    tick();
    drive(4'b0101, 12'o4321, 12'o0017);
    tick();
    drive(4'b1110, 12'o7070, 12'o0707);
    tick();
    drive(4'b0011, 12'o6655, 12'o4433);
    tick();
    drive(4'b1000, 12'o5111, 12'o6222);
    tick();
    drive(4'b0000, 12'o0, 12'o0);
    tick();
    drive(4'b1111, 12'o1357, 12'o2460);
    repeat (3) tick();
    drive(4'b0000, 12'o0, 12'o0);
    repeat (3) tick();

`ifdef MULT_TABLE_ARB_SELFCHECK_EN
    drive(4'b0001, 12'o0006, 12'o0006);
    tick();
    drive(4'b0001, 12'o0005, 12'o0005);
    tick();
    drive(4'b0000, 12'o0, 12'o0);
    @(negedge clk);
    chk("err_bad", int'(bus.rsp_err), 1);
    chk("err_bad_result", int'(bus.rsp_result), 35);
    tick();
    @(negedge clk);
    chk("err_good", int'(bus.rsp_err), 0);
    chk("err_good_result", int'(bus.rsp_result), 25);
    tick();
`endif

    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mult_table_arbiter.md
# mult_table_arbiter

Round-robin controller that shares the single-port 8x8 times-table memory (64 x 6-bit, synchronous read) between `NREQ` requesters. Each requester presents operands `a`, `b` with a valid/ready handshake. The arbiter grants one request per cycle, drives the memory enable and address, and tracks the memory's one-cycle read latency. It returns each product to the originating requester with a one-hot response strobe. It sits between the client logic and the multiplier memory instance.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, 2..8.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `req_valid`  in  NREQ: request pending, one bit per requester.
- `req_a`  in  3*NREQ: operand a, requester i at bits [3i+2:3i].
- `req_b`  in  3*NREQ: operand b, same packing as `req_a`.
- `req_ready`  out  NREQ: one-hot grant; the handshake completes when `req_valid[i] & req_ready[i]`.
- `rsp_valid`  out  NREQ: one-hot, one-cycle strobe marking the response owner.
- `rsp_result`  out  6: the product a*b, valid while any `rsp_valid` bit is set.
- `mem_en`  out  1: memory read enable.
- `mem_addr`  out  6: memory address, {a,b}.
- `mem_data`  in  6: memory read data, registered inside the memory with one cycle of latency.

## Operation
- **Arbitration.** Combinational grant each cycle.
  - Search order starts at `(last_grant+1) mod NREQ` and wraps.
  - `req_ready` is asserted only to the first requester with `req_valid` high.
  - `last_grant` updates only on a completed handshake.
- **Issue.** On a handshake from requester g in cycle T:
  - `mem_en`=1 and `mem_addr`={req_a[g],req_b[g]} in T.
  - With no handshake, `mem_en`=0 and `mem_addr` holds its last value.
- **Pipeline tags.**
  - Stage 1 register: {valid, owner} for the issued read.
  - Stage 2 register: {valid, owner, data captured from `mem_data`}.
- **Response.** `rsp_valid[owner]` and `rsp_result` are driven from stage 2.
- **No backpressure.** There is no backpressure on responses; requesters must accept on the strobe cycle.
- **Ignored memory data.** Stale `mem_data` in cycles without a stage-1 valid is ignored. `rsp_result` holds its last value when `rsp_valid`=0.
- **Width rules.** Operands are unsigned 3-bit. The result is unsigned 6-bit, maximum 49 (7x7). No truncation occurs.
- **Per-requester behaviour.** A requester may hold `req_valid` high across back-to-back grants. Ordering is preserved per requester.

## Timing
- **Throughput.** One grant per cycle.
- **Latency.** Fixed at 2 cycles. Handshake in T gives `mem_data` valid in T+1 and `rsp_valid` in T+2.
- **Reset values.**
  - `req_ready`=0, `rsp_valid`=0, `rsp_result`=0, `mem_en`=0, `mem_addr`=0.
  - Both pipeline valids are 0.
  - `last_grant`=NREQ-1, so requester 0 has first priority.
- **Reset asserted mid-operation.** In-flight reads are discarded. No `rsp_valid` appears in the two cycles after `rst_n` returns high unless new handshakes occur.
- **Reset and ready.** While `rst_n`=0, `req_ready` is forced to 0.
- **Idle and single requester.**
  - With all `req_valid` low, there is no grant and `last_grant` is unchanged.
  - A single continuously valid requester is granted every cycle.
- **Contention.** With all NREQ requesters valid continuously, grants rotate 0,1,…,NREQ-1,0 with no requester starved. Each requester waits at most NREQ-1 cycles.
- **Simultaneous events.** A response for one requester and a new grant to the same requester in the same cycle are independent and both occur.

## Configuration
- **`MULT_TABLE_ARB_SELFCHECK_EN` defined:**
  - Stage 1 and stage 2 also carry the operands.
  - Stage 2 compares the captured `mem_data` against the computed a*b.
  - Adds port `rsp_err` (out, 1): high with `rsp_valid` when the values mismatch, reset 0.
- **Macro undefined:** the port, the extra operand registers and the comparator are absent. Behaviour is otherwise identical.

## Structure
- **Package `mult_table_pkg`** holds:
  - `OP_W`=3, `RES_W`=6, `ADDR_W`=6.
  - `MAX_NREQ`=8.
  - Typedefs `operand_t`, `result_t`, `mem_addr_t`.
- **Sub-module `rr_grant`:** parameterised NREQ round-robin picker. Inputs are the request vector and `last_grant`; outputs are the one-hot grant and the encoded index. It is purely combinational.
- **Top-level:** handshake, pipeline tag registers, memory drive, and the optional self-check.

## Test plan
- **Single request:** after reset, `req_valid`=0001, a0=3, b0=5 for one cycle → `mem_en`=1 and `mem_addr`=6'o35 that cycle; `rsp_valid`=0001 and `rsp_result`=15 two cycles later.
- **Contention:** all four valid for 8 cycles with a_i=i, b_i=7 → grant order 0,1,2,3,0,1,2,3; responses 0,7,14,21 repeating, each at +2 cycles.
- **Maximum product:** requester 2 streams a=7, b=7 for 5 cycles → 5 consecutive `rsp_valid`=0100 with result 49; `mem_en` high for 5 cycles.
- **Reset mid-flight:** `rst_n` low for one cycle, one cycle after a grant → no `rsp_valid` afterwards, all outputs 0, and the next grant goes to requester 0.
- **Fairness after idle:** grant to requester 1, then idle 3 cycles, then requesters 0 and 3 valid → requester 3 is granted first, then requester 0.
- **Self-check (macro defined):** the memory model corrupts the entry for 6x6 to 35 → `rsp_err`=1 on that response and 0 on all others.
